branch_checkpoint_manager: RTL

BRANCH_CHECKPOINT_MANAGER -- requirements
Module: branch_checkpoint_manager

---
 rtl/branch_checkpoint_manager_pkg.sv | 34 +++
 rtl/branch_checkpoint_manager_ifc.sv | 27 ++
 rtl/branch_checkpoint_manager_stats.sv | 50 +++++
 rtl/branch_checkpoint_manager.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/branch_checkpoint_manager_pkg.sv
// Shared sizing macros, types and helpers for the branch checkpoint table.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
`ifndef BRANCH_CKPT_DEFS_SVH
`define BRANCH_CKPT_DEFS_SVH
`define BRANCH_NUM             4
`define BRANCH_NUM_INDEX       2
`define REG_NUM                32
`define PHYS_REG_NUM_INDEX     6
`define ACTIVE_LIST_SIZE_INDEX 5
`endif

package branch_checkpoint_manager_pkg;

    localparam int BRANCH_NUM = `BRANCH_NUM;

    // Delay-slot tracking FSM: after a branch is checkpointed we wait for its
    // delay slot to be renamed so the snapshot can be refreshed.
    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        DS_PENDING = 1'b1
    } ds_state_t;

    typedef logic [`BRANCH_NUM_INDEX-1:0] bidx_t;

    // Checkpoint slot pointer increment with wrap at the table size.
    function automatic bidx_t next_ptr(input bidx_t p);
        if (p == bidx_t'(BRANCH_NUM - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/branch_checkpoint_manager_ifc.sv
// Hazard and checkpoint-state bundles exchanged with rename/recovery logic.
// Latency: n/a (wiring only).
// Backpressure: n/a (wiring only).

interface hazard_signals_ifc;
    logic branch_miss;
    modport in  (input  branch_miss);
    modport out (output branch_miss);
endinterface

interface branch_state_ifc;
    import branch_checkpoint_manager_pkg::*;
    logic [`BRANCH_NUM-1:0]                                           valid;
    logic [`BRANCH_NUM-1:0]                                           ds_valid;
    logic [`BRANCH_NUM_INDEX-1:0]                                     write_pointer;
    logic [`BRANCH_NUM_INDEX-1:0]                                     last_idx;
    ds_state_t                                                        state;
    logic [`BRANCH_NUM-1:0][`ACTIVE_LIST_SIZE_INDEX-1:0]              branch_id;
    logic [`BRANCH_NUM-1:0][`PHYS_REG_NUM_INDEX-1:0]                  free_head_pointer;
    logic [`BRANCH_NUM-1:0][`REG_NUM-1:0][`PHYS_REG_NUM_INDEX-1:0]    rename_buffer;

    // Recovery only needs the surviving valid vector and the write pointer.
    modport in  (input  valid, input write_pointer);
    modport out (output valid, output ds_valid, output write_pointer, output last_idx,
                 output state, output branch_id, output free_head_pointer,
                 output rename_buffer);
endinterface

// File: rtl/branch_checkpoint_manager_stats.sv
// Saturating event counters for checkpoint allocation, misses and full stalls.
// Latency: 1 cycle from event to count update.
// Backpressure: none; counters hold at all ones instead of wrapping.
`ifdef BRANCH_CKPT_STATS_EN

module branch_ckpt_sat_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

module branch_ckpt_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alloc_evt_i,
    input  logic        miss_evt_i,
    input  logic        stall_evt_i,
    output logic [31:0] alloc_cnt_o,
    output logic [31:0] miss_cnt_o,
    output logic [31:0] stall_cnt_o
);
    branch_ckpt_sat_cnt u_alloc_cnt (.clk(clk), .rst_n(rst_n), .inc_i(alloc_evt_i), .cnt_o(alloc_cnt_o));
    branch_ckpt_sat_cnt u_miss_cnt  (.clk(clk), .rst_n(rst_n), .inc_i(miss_evt_i),  .cnt_o(miss_cnt_o));
    branch_ckpt_sat_cnt u_stall_cnt (.clk(clk), .rst_n(rst_n), .inc_i(stall_evt_i), .cnt_o(stall_cnt_o));
endmodule

`endif

// File: rtl/branch_checkpoint_manager.sv
// Branch checkpoint table: snapshots rename state per in-flight branch, refreshed after the delay slot.
// Latency: 1-cycle write; all outputs come straight from registers. Optional stats via BRANCH_CKPT_STATS_EN.
// Backpressure: ckpt_full (slot at write_pointer still valid) stalls new branches at rename.

module branch_checkpoint_manager
    import branch_checkpoint_manager_pkg::*;
(
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   alloc_valid,
    input  logic [`ACTIVE_LIST_SIZE_INDEX-1:0]                     alloc_branch_id,
    input  logic [`PHYS_REG_NUM_INDEX-1:0]                         snap_free_head_pointer,
    input  logic [`REG_NUM-1:0][`PHYS_REG_NUM_INDEX-1:0]           snap_rename_buffer,
    input  logic                                                   ds_valid_in,
    input  logic                                                   resolve_valid,
    input  logic [`ACTIVE_LIST_SIZE_INDEX-1:0]                     resolve_branch_id,
    hazard_signals_ifc.in                                          hazard_signal_in,
    branch_state_ifc.in                                            misprediction_branch_state,
    branch_state_ifc.out                                           curr_branch_state,
    output logic                                                   ckpt_full
`ifdef BRANCH_CKPT_STATS_EN
    ,
    output logic [31:0]                                            stat_alloc_count,
    output logic [31:0]                                            stat_miss_count,
    output logic [31:0]                                            stat_full_stall_count
`endif
);

    logic [`BRANCH_NUM-1:0]                                        valid_q, valid_d;
    logic [`BRANCH_NUM-1:0]                                        ds_valid_q, ds_valid_d;
    bidx_t                                                         wp_q, wp_d;
    bidx_t                                                         last_idx_q, last_idx_d;
    ds_state_t                                                     state_q, state_d;
    logic [`BRANCH_NUM-1:0][`ACTIVE_LIST_SIZE_INDEX-1:0]           branch_id_q, branch_id_d;
    logic [`BRANCH_NUM-1:0][`PHYS_REG_NUM_INDEX-1:0]               fhp_q, fhp_d;
    logic [`BRANCH_NUM-1:0][`REG_NUM-1:0][`PHYS_REG_NUM_INDEX-1:0] rb_q, rb_d;

    logic branch_miss;
    logic alloc_fire;
    logic ds_fire;

    assign branch_miss = hazard_signal_in.branch_miss;
    assign ckpt_full   = valid_q[wp_q];

    // A miss cycle discards both allocation and delay-slot refresh.
    assign alloc_fire = alloc_valid && !ckpt_full && !branch_miss && (state_q == IDLE);
    assign ds_fire    = ds_valid_in && !branch_miss && (state_q == DS_PENDING);

    // Delay-slot FSM next state; a miss always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (branch_miss) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:       if (alloc_fire) state_d = DS_PENDING;
                DS_PENDING: if (ds_valid_in) state_d = IDLE;
                default:    state_d = IDLE;
            endcase
        end
    end

    // Table next state: recovery base, then resolve clears, then new allocation / DS refresh.
    always_comb begin
        valid_d     = valid_q;
        ds_valid_d  = ds_valid_q;
        wp_d        = wp_q;
        last_idx_d  = last_idx_q;
        branch_id_d = branch_id_q;
        fhp_d       = fhp_q;
        rb_d        = rb_q;

        if (branch_miss) begin
            valid_d = misprediction_branch_state.valid;
            wp_d    = misprediction_branch_state.write_pointer;
        end

        // Clearing a slot that is already invalid is harmless; allocation below wins its slot.
        if (resolve_valid) begin
            for (int i = 0; i < BRANCH_NUM; i++) begin
                if (branch_id_q[i] == resolve_branch_id) begin
                    valid_d[i] = 1'b0;
                end
            end
        end

        if (alloc_fire) begin
            branch_id_d[wp_q] = alloc_branch_id;
            fhp_d[wp_q]       = snap_free_head_pointer;
            rb_d[wp_q]        = snap_rename_buffer;
            valid_d[wp_q]     = 1'b1;
            ds_valid_d[wp_q]  = 1'b0;
            wp_d              = next_ptr(wp_q);
            last_idx_d        = wp_q;
        end

        if (ds_fire) begin
            fhp_d[last_idx_q]      = snap_free_head_pointer;
            rb_d[last_idx_q]       = snap_rename_buffer;
            ds_valid_d[last_idx_q] = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Checkpoint table registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= '0;
            ds_valid_q  <= '0;
            wp_q        <= '0;
            last_idx_q  <= '0;
            branch_id_q <= '0;
            fhp_q       <= '0;
            rb_q        <= '0;
        end else begin
            valid_q     <= valid_d;
            ds_valid_q  <= ds_valid_d;
            wp_q        <= wp_d;
            last_idx_q  <= last_idx_d;
            branch_id_q <= branch_id_d;
            fhp_q       <= fhp_d;
            rb_q        <= rb_d;
        end
    end

    assign curr_branch_state.valid             = valid_q;
    assign curr_branch_state.ds_valid          = ds_valid_q;
    assign curr_branch_state.write_pointer     = wp_q;
    assign curr_branch_state.last_idx          = last_idx_q;
    assign curr_branch_state.state             = state_q;
    assign curr_branch_state.branch_id         = branch_id_q;
    assign curr_branch_state.free_head_pointer = fhp_q;
    assign curr_branch_state.rename_buffer     = rb_q;

    // A branch inside a delay slot is illegal; miss cycles drop the request anyway.
    a_no_alloc_in_ds: assert property (@(posedge clk) disable iff (!rst_n)
        !(alloc_valid && (state_q == DS_PENDING) && !branch_miss));

`ifdef BRANCH_CKPT_STATS_EN
    branch_ckpt_stats u_stats (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_evt_i (alloc_fire),
        .miss_evt_i  (branch_miss),
        .stall_evt_i (alloc_valid && ckpt_full),
        .alloc_cnt_o (stat_alloc_count),
        .miss_cnt_o  (stat_miss_count),
        .stall_cnt_o (stat_full_stall_count)
    );
`endif

endmodule
